md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Sequences the multi-cycle multiplier and divider that sit beside the ALU in the execute stage, and shares them as one resource.
- Accepts one M-extension op at a time from ID/EX, issues it to the matching unit, and stalls the pipeline until the result is back.
- Returns the result with a one-cycle valid pulse.
- Resolves RISC-V divide-by-zero and signed-overflow cases itself, without starting the divider.

Parameters:
XLEN, 32, operand/result width
TIMEOUT, 64, max WAIT cycles before forced completion (≥2)

Ports:
clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
req_valid  in  1  ID/EX holds an M-extension op
req_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_a  in  XLEN  forwarded rs1
req_b  in  XLEN  forwarded rs2
flush  in  1  kill in-flight op
hold  in  1  dbg or mem_hold freeze
unit_start  out  1  one-cycle start pulse to selected unit
unit_sel  out  3  latched funct3 to units
unit_a  out  XLEN  latched operand a
unit_b  out  XLEN  latched operand b
mul_ready  in  1  multiplier done
mul_res  in  XLEN  multiplier result
div_ready  in  1  divider done
div_res  in  XLEN  divider result
stall  out  1  freeze IF/ID/EX
res_valid  out  1  result valid
res  out  XLEN  result
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (Rst_n low, async): state IDLE, all registered outputs 0, timeout_err 0, counter 0. Reset mid-op abandons the op with no res_valid.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Accepts when req_valid & !hold & !flush.
  - stall is combinational, = req_valid & !flush, so it asserts the same cycle as the accept.
  - Latches funct3, a and b.
  - Special case: funct3[2]=1 and b==0 → DONE. Result is all-ones for DIV/DIVU, a for REM/REMU.
  - Special case: funct3==4 or 6, a==0x8000_0000 and b==all-ones → DONE. Result is 0x8000_0000 for DIV, 0 for REM.
  - All other ops → ISSUE.
- ISSUE:
  - unit_start=1 for exactly one cycle; stall=1; counter cleared → WAIT.
  - unit_sel, unit_a and unit_b stay stable from ISSUE through WAIT.
- WAIT:
  - stall=1.
  - Only the ready of the selected unit is honoured: mul_ready when funct3[2]=0, div_ready when funct3[2]=1. The other ready is ignored.
  - Ready is not sampled during ISSUE.
  - On ready: capture the unit result → DONE.
  - Counter increments each cycle. At count==TIMEOUT-1 without ready: res=0, timeout_err←1 → DONE.
- DONE:
  - res_valid=1 and stall=0, so EX/MEM captures res.
  - If hold=1, stay in DONE with res and res_valid stable.
  - Else → IDLE.
  - A back-to-back req_valid the next cycle is accepted normally from IDLE.
- Latency:
  - Normal path: accept cycle, then ISSUE, then N WAIT cycles, then DONE. Stall covers accept through the last WAIT cycle.
  - Fast path: stall for one cycle, DONE on the next.
- flush in any state → IDLE next cycle. No res_valid; any later unit ready is ignored. flush overrides ready in the same cycle.
- hold in ISSUE/WAIT does not pause the sequencer: the unit is already running. Only the DONE exit waits on hold.
- timeout_err is cleared only by reset.
- res holds its last value in IDLE.

Decomposition:
- Shared package md_pkg holds:
  - the md_state_t enum (IDLE, ISSUE, WAIT, DONE);
  - funct3 localparams F3_MUL…F3_REMU;
  - the INT_MIN constant.
- One sub-module, md_special_case: combinational detection of divide-by-zero and overflow, plus the fixed result.
- The FSM, latches and watchdog stay in md_sequencer.

Test Plan:
- MUL a=7, b=6; mul_ready 3 cycles after start, mul_res=42 → one unit_start pulse, stall for 5 cycles, then res_valid with res=42.
- DIVU a=100, b=0 → no unit_start, stall 1 cycle, res=0xFFFF_FFFF; REMU same operands → res=100.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → res=0x8000_0000; REM same operands → res=0. No unit_start in either case.
- DIV 20/3, with a spurious mul_ready pulse during WAIT, then div_ready with div_res=6 → the spurious pulse is ignored, res=6.
- REM op, flush asserted 2 cycles into WAIT, div_ready later → no res_valid, IDLE next cycle, next MUL 3×3 returns 9.
- TIMEOUT=8, no ready ever → res_valid after 8 WAIT cycles with res=0 and timeout_err=1. Hold during DONE keeps res_valid high. Rst_n low clears all outputs asynchronously.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the M-extension sequencer.
// - md_state_t : sequencer FSM states
// - F3_*       : funct3 encodings of the M-extension ops
// - INT_MIN    : most negative 32-bit signed value (signed-overflow dividend)
package md_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } md_state_t;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/md_special_case.sv
// Combinational detection of divide/remainder ops whose RISC-V result is
// fixed, so the divider never has to be started for them.
// Ports:
//   i_funct3  : op encoding
//   i_a, i_b  : dividend / divisor
//   o_special : op resolves without the divider
//   o_res     : fixed result (valid when o_special)
module md_special_case
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_special,
  output logic [XLEN-1:0] o_res
);

  // Most negative value at the configured width.
  localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic w_div_zero;
  logic w_ovf;

  // funct3[2] marks the divider ops; funct3[1] distinguishes REM from DIV.
  assign w_div_zero = i_funct3[2] && (i_b == '0);
  assign w_ovf      = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                      (i_a == W_MIN) && (i_b == '1);
  assign o_special  = w_div_zero || w_ovf;

  always_comb begin
    o_res = '0;
    if (w_div_zero) begin
      o_res = i_funct3[1] ? i_a : '1;
    end else if (w_ovf) begin
      o_res = i_funct3[1] ? '0 : W_MIN;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Sequencer sharing one multiplier and one divider between M-extension ops
// issued from ID/EX. Latches one op, starts the matching unit, stalls the
// pipeline until the result returns and presents it with res_valid.
//
// Handshake: an op is accepted in IDLE when req_valid & !hold & !flush.
// unit_start is a single-cycle pulse; the unit answers with a one-cycle
// ready pulse, and only the ready of the selected unit is honoured, only in
// WAIT. res_valid is high for every cycle spent in DONE; the consumer takes
// res on any such cycle and hold extends DONE.
//
// Ports:
//   clk, Rst_n               : clock, async active-low reset
//   req_valid/funct3/a/b     : op request from ID/EX
//   flush, hold              : kill in-flight op / freeze DONE exit
//   unit_start/sel/a/b       : command to the multiplier and divider
//   mul_ready/res, div_ready/res : unit completions
//   stall                    : pipeline freeze
//   res_valid, res           : result
//   timeout_err              : sticky watchdog flag
//   dbg_state                : current FSM state
module md_sequencer
  import md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            Rst_n,
  input  logic            req_valid,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  input  logic            hold,
  output logic            unit_start,
  output logic [2:0]      unit_sel,
  output logic [XLEN-1:0] unit_a,
  output logic [XLEN-1:0] unit_b,
  input  logic            mul_ready,
  input  logic [XLEN-1:0] mul_res,
  input  logic            div_ready,
  input  logic [XLEN-1:0] div_res,
  output logic            stall,
  output logic            res_valid,
  output logic [XLEN-1:0] res,
  output logic            timeout_err,
  output md_state_t       dbg_state
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  md_state_t       r_state;
  md_state_t       w_next;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_res;
  logic [CW-1:0]   r_cnt;
  logic            r_terr;

  logic            w_accept;
  logic            w_sel_ready;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_latch;
  logic            w_cap_special;
  logic            w_cap_unit;
  logic            w_cap_timeout;
  logic            w_cnt_clr;
  logic            w_cnt_inc;

  // Special cases are judged on the live request so the fast path can go
  // straight from the accept cycle to DONE.
  md_special_case #(.XLEN(XLEN)) u_special (
    .i_funct3  (req_funct3),
    .i_a       (req_a),
    .i_b       (req_b),
    .o_special (w_special),
    .o_res     (w_special_res)
  );

  assign w_accept    = req_valid && !hold && !flush;
  assign w_sel_ready = r_f3[2] ? div_ready : mul_ready;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    stall         = 1'b0;
    unit_start    = 1'b0;
    res_valid     = 1'b0;
    w_latch       = 1'b0;
    w_cap_special = 1'b0;
    w_cap_unit    = 1'b0;
    w_cap_timeout = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        // Stall follows the request even under hold so ID/EX keeps the op.
        stall = req_valid && !flush;
        if (w_accept) begin
          w_latch = 1'b1;
          if (w_special) begin
            w_cap_special = 1'b1;
            w_next        = DONE;
          end else begin
            w_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        // The start pulse goes out even if flushed; the unit's answer is
        // then ignored because the FSM is back in IDLE.
        unit_start = 1'b1;
        stall      = 1'b1;
        w_cnt_clr  = 1'b1;
        w_next     = flush ? IDLE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (flush) begin
          w_next = IDLE;
        end else if (w_sel_ready) begin
          w_cap_unit = 1'b1;
          w_next     = DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_cap_timeout = 1'b1;
          w_next        = DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (flush || !hold) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_f3   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else begin
      if (w_latch) begin
        r_f3 <= req_funct3;
        r_a  <= req_a;
        r_b  <= req_b;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // r_res only changes on entry to DONE, so it holds through IDLE.
      if (w_cap_special) begin
        r_res <= w_special_res;
      end else if (w_cap_unit) begin
        r_res <= r_f3[2] ? div_res : mul_res;
      end else if (w_cap_timeout) begin
        r_res  <= '0;
        r_terr <= 1'b1;
      end
    end
  end

  assign unit_sel    = r_f3;
  assign unit_a      = r_a;
  assign unit_b      = r_b;
  assign res         = r_res;
  assign timeout_err = r_terr;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  import md_pkg::*;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 8;

  logic            clk;
  logic            Rst_n;
  logic            req_valid;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            flush;
  logic            hold;
  logic            unit_start;
  logic [2:0]      unit_sel;
  logic [XLEN-1:0] unit_a;
  logic [XLEN-1:0] unit_b;
  logic            mul_ready;
  logic [XLEN-1:0] mul_res;
  logic            div_ready;
  logic [XLEN-1:0] div_res;
  logic            stall;
  logic            res_valid;
  logic [XLEN-1:0] res;
  logic            timeout_err;
  md_state_t       dbg_state;

  md_sequencer #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .Rst_n       (Rst_n),
    .req_valid   (req_valid),
    .req_funct3  (req_funct3),
    .req_a       (req_a),
    .req_b       (req_b),
    .flush       (flush),
    .hold        (hold),
    .unit_start  (unit_start),
    .unit_sel    (unit_sel),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .mul_ready   (mul_ready),
    .mul_res     (mul_res),
    .div_ready   (div_ready),
    .div_res     (div_res),
    .stall       (stall),
    .res_valid   (res_valid),
    .res         (res),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic        exp_terr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    p  = '0;
    case (f3)
      F3_MUL: begin
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
      end
      F3_MULH: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p[63:32];
      end
      F3_MULHSU: begin
        p = {{32{a[31]}}, a} * {32'b0, b};
        return p[63:32];
      end
      F3_MULHU: begin
        p = {32'b0, a} * {32'b0, b};
        return p[63:32];
      end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
        return 32'(sa / sb);
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
    if (f3 < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return ((f3 == F3_DIV) || (f3 == F3_REM)) && (a == INT_MIN) && (b == 32'hFFFF_FFFF);
  endfunction

  // ---------------- driver ----------------
  // Runs one complete op, playing the part of the unit. Starts in IDLE at
  // posedge+1 and returns at posedge+1 of the cycle after DONE.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int delay, input bit spurious, input logic [31:0] exp_res,
                        input bit exp_fast);
    int          stall_cnt;
    int          start_cnt;
    logic [31:0] exp_v;
    stall_cnt = 0;
    start_cnt = 0;
    check("idle_res_valid", res_valid, 0);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_a      = a;
    req_b      = b;
    exp_q.push_back(exp_res);
    #1;
    check("accept_stall", stall, 1);
    stall_cnt += int'(stall);
    start_cnt += int'(unit_start);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_funct3 = 3'($urandom);
    req_a      = $urandom;
    req_b      = $urandom;
    if (!exp_fast) begin
      // A ready during ISSUE must not be sampled.
      if (f3[2]) begin div_ready = spurious; div_res = ~exp_res; end
      else       begin mul_ready = spurious; mul_res = ~exp_res; end
      #1;
      check("issue_start", unit_start, 1);
      check("issue_sel", unit_sel, f3);
      check("issue_a", unit_a, a);
      check("issue_b", unit_b, b);
      check("issue_res_valid", res_valid, 0);
      stall_cnt += int'(stall);
      start_cnt += int'(unit_start);
      @(posedge clk); #1;
      for (int i = 1; i <= delay; i++) begin
        if (f3[2]) begin
          div_ready = (i == delay); div_res = exp_res;
          mul_ready = spurious && (i == 1); mul_res = ~exp_res;
        end else begin
          mul_ready = (i == delay); mul_res = exp_res;
          div_ready = spurious && (i == 1); div_res = ~exp_res;
        end
        #1;
        check("wait_res_valid", res_valid, 0);
        check("wait_sel", unit_sel, f3);
        check("wait_b", unit_b, b);
        stall_cnt += int'(stall);
        start_cnt += int'(unit_start);
        @(posedge clk); #1;
        mul_ready = 1'b0;
        div_ready = 1'b0;
      end
    end
    #1;
    exp_v = exp_q.pop_front();
    check("done_res_valid", res_valid, 1);
    check("done_res", res, exp_v);
    check("done_stall", stall, 0);
    check("done_timeout_err", timeout_err, exp_terr);
    start_cnt += int'(unit_start);
    check("stall_cycles", stall_cnt, exp_fast ? 1 : delay + 2);
    check("start_pulses", start_cnt, exp_fast ? 0 : 1);
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    bit          spurious;
    logic [31:0] exp_res;
    bit          fast;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{F3_MUL,    32'd7,         32'd6,         3, 1'b0, 32'd42,        1'b0};
    vecs[1]  = '{F3_DIVU,   32'd100,       32'd0,         0, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[2]  = '{F3_REMU,   32'd100,       32'd0,         0, 1'b0, 32'd100,       1'b1};
    vecs[3]  = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32'h8000_0000, 1'b1};
    vecs[4]  = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32'd0,         1'b1};
    vecs[5]  = '{F3_DIV,    32'd20,        32'd3,         3, 1'b1, 32'd6,         1'b0};
    vecs[6]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFE, 1'b0};
    vecs[7]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         2, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{F3_REM,    32'hFFFF_FFF9, 32'd2,         4, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{F3_DIV,    32'hFFFF_FFF9, 32'd2,         5, 1'b1, 32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{F3_DIV,    32'd0,         32'd0,         0, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{F3_REM,    32'd5,         32'd0,         0, 1'b0, 32'd5,         1'b1};
    vecs[12] = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 2, 1'b0, 32'h4000_0000, 1'b0};
    vecs[13] = '{F3_DIV,    32'h8000_0000, 32'd1,         1, 1'b1, 32'h8000_0000, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    n_checks   = 0;
    n_fail     = 0;
    exp_terr   = 1'b0;
    Rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_funct3 = '0;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    hold       = 1'b0;
    mul_ready  = 1'b0;
    mul_res    = '0;
    div_ready  = 1'b0;
    div_res    = '0;

    // reset state
    #23;
    check("rst_state", dbg_state, IDLE);
    check("rst_res_valid", res_valid, 0);
    check("rst_res", res, 0);
    check("rst_start", unit_start, 0);
    check("rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    Rst_n = 1'b1;
    @(posedge clk); #1;

    // directed table, issued back to back
    for (int v = 0; v < NV; v++) begin
      run_op(vecs[v].f3, vecs[v].a, vecs[v].b, vecs[v].delay, vecs[v].spurious,
             vecs[v].exp_res, vecs[v].fast);
    end

    // hold in IDLE blocks acceptance but still stalls
    req_valid = 1'b1; req_funct3 = F3_MUL; req_a = 32'd2; req_b = 32'd2; hold = 1'b1;
    #1;
    check("idle_hold_stall", stall, 1);
    @(posedge clk); #1;
    check("idle_hold_state", dbg_state, IDLE);
    check("idle_hold_start", unit_start, 0);
    req_valid = 1'b0; hold = 1'b0;

    // flush two cycles into WAIT, with the divider answering in the same cycle
    req_valid = 1'b1; req_funct3 = F3_REM; req_a = 32'd20; req_b = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1; div_ready = 1'b1; div_res = 32'h1234;
    @(posedge clk); #1;
    flush = 1'b0; div_ready = 1'b0;
    #1;
    check("flush_state", dbg_state, IDLE);
    check("flush_res_valid", res_valid, 0);
    check("flush_stall", stall, 0);
    div_ready = 1'b1;
    @(posedge clk); #1;
    div_ready = 1'b0;
    check("late_ready_res_valid", res_valid, 0);
    check("late_ready_state", dbg_state, IDLE);
    run_op(F3_MUL, 32'd3, 32'd3, 2, 1'b0, 32'd9, 1'b0);

    // randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = INT_MIN; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 9));
      run_op(f3, a, b, $urandom_range(1, TIMEOUT - 2), 1'($urandom_range(0, 1)),
             ref_md(f3, a, b), ref_fast(f3, a, b));
    end

    // watchdog: wrong-unit ready only, hold through the last WAIT and DONE
    req_valid = 1'b1; req_funct3 = F3_DIVU; req_a = 32'd50; req_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mul_ready = 1'b1; mul_res = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      if (i == TIMEOUT) hold = 1'b1;
      #1;
      check("to_wait_stall", stall, 1);
      check("to_wait_res_valid", res_valid, 0);
      @(posedge clk); #1;
    end
    mul_ready = 1'b0;
    check("to_done_res_valid", res_valid, 1);
    check("to_done_res", res, 0);
    check("to_timeout_err", timeout_err, 1);
    check("to_done_stall", stall, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("hold_res_valid", res_valid, 1);
      check("hold_res", res, 0);
      check("hold_state", dbg_state, DONE);
    end
    hold = 1'b0;
    @(posedge clk); #1;
    check("to_exit_res_valid", res_valid, 0);
    check("to_sticky", timeout_err, 1);
    exp_terr = 1'b1;
    run_op(F3_MUL, 32'd4, 32'd5, 1, 1'b0, 32'd20, 1'b0);

    // asynchronous reset in the middle of an op
    req_valid = 1'b1; req_funct3 = F3_MULHU; req_a = 32'd5; req_b = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst_state", dbg_state, IDLE);
    check("arst_stall", stall, 0);
    check("arst_start", unit_start, 0);
    check("arst_sel", unit_sel, 0);
    check("arst_a", unit_a, 0);
    check("arst_b", unit_b, 0);
    check("arst_res", res, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_timeout_err", timeout_err, 0);
    @(negedge clk);
    Rst_n = 1'b1;
    @(posedge clk); #1;
    mul_ready = 1'b1;
    @(posedge clk); #1;
    mul_ready = 1'b0;
    check("arst_abandon_res_valid", res_valid, 0);
    exp_terr = 1'b0;
    run_op(F3_DIVU, 32'd17, 32'd4, 2, 1'b1, 32'd4, 1'b0);

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
